dma_service_arbiter: RTL and testbench

- Channel service sequencer for the 8237A-style DMA.
- Arbitrates the four channel requests (hardware DREQ plus software request) under fixed or rotating priority.
- Runs the HRQ/HLDA bus handshake and drives DACK and the active-channel index to the timing/control and datapath blocks.
- Owns the mask, software-request and TC-status bits, and the per-channel service-termination rules (single/block/demand/cascade, TC/EOP, autoinit).

---
 rtl/dma_service_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dma_service_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_service_arbiter.sv
// Channel service sequencer for an 8237A-style DMA: request arbitration,
// HRQ/HLDA handshake, DACK generation and per-channel termination/status.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request outstanding, waiting for an eligible channel
// ST_REQ   | hrq raised, waiting for hlda to latch the winning channel
// ST_SVC   | channel act_ch granted, dack/svc_valid active
// ST_REL   | hrq/dack dropped, waiting for hlda to fall
module dma_service_arbiter #(
   parameter int NCH  = 4,
   parameter int CH_W = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NCH-1:0]    dreq,
   input  logic              dreq_pol,
   input  logic              dack_pol,
   input  logic              rot_pri,
   input  logic              ctrl_disable,
   input  logic [2*NCH-1:0]  mode,
   input  logic [NCH-1:0]    autoinit,
   input  logic              mask_we,
   input  logic [NCH-1:0]    mask_wdata,
   input  logic              swreq_we,
   input  logic [CH_W-1:0]   swreq_ch,
   input  logic              swreq_set,
   input  logic              status_rd,
   input  logic              hlda,
   input  logic              xfer_done,
   input  logic              tc,
   input  logic              eop_n,
   output logic              hrq,
   output logic [NCH-1:0]    dack,
   output logic [CH_W-1:0]   act_ch,
   output logic              svc_valid,
   output logic [NCH-1:0]    mask_q,
   output logic [NCH-1:0]    req_q,
   output logic [NCH-1:0]    tc_status
);

   localparam logic [1:0] MD_DEMAND  = 2'b00;
   localparam logic [1:0] MD_SINGLE  = 2'b01;
   localparam logic [1:0] MD_BLOCK   = 2'b10;
   localparam logic [1:0] MD_CASCADE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_SVC  = 2'b10,
      ST_REL  = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   act_q, act_d;
   logic [CH_W-1:0]   pri_base, pri_base_d;
   logic [NCH-1:0]    dreq_q;
   logic [NCH-1:0]    mask_d, req_d, tc_status_d;
   logic [NCH-1:0]    eligible;
   logic [NCH-1:0]    dack_int;
   logic [1:0]        act_mode;
   logic              win_found;
   logic [CH_W-1:0]   win_ch;
   logic [CH_W-1:0]   search_start;
   logic [CH_W-1:0]   cand;
   logic              tc_evt;

   // Cascade channels only forward the downstream controller's DREQ.
   always_comb begin
      eligible = '0;
      for (int c = 0; c < NCH; c++) begin
         if (mode[2*c +: 2] == MD_CASCADE)
            eligible[c] = dreq_q[c] & ~mask_q[c];
         else
            eligible[c] = (dreq_q[c] | req_q[c]) & ~mask_q[c];
      end
   end

   always_comb begin
      win_found    = 1'b0;
      win_ch       = '0;
      cand         = '0;
      search_start = rot_pri ? pri_base : '0;
      for (int i = 0; i < NCH; i++) begin
         cand = search_start + CH_W'(i);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_ch    = cand;
         end
      end
   end

   assign act_mode = mode[{act_q, 1'b0} +: 2];

   always_comb begin
      state_d    = state_q;
      act_d      = act_q;
      tc_evt     = 1'b0;
      pri_base_d = pri_base;
      case (state_q)
         ST_IDLE: begin
            if (!ctrl_disable && win_found)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (hlda) begin
               if (win_found) begin
                  state_d = ST_SVC;
                  act_d   = win_ch;
               end else begin
                  state_d = ST_REL;
               end
            end
         end
         ST_SVC: begin
            if (!hlda) begin
               state_d = ST_REL;
            end else if (act_mode == MD_CASCADE) begin
               if (!dreq_q[act_q])
                  state_d = ST_REL;
            end else if (xfer_done) begin
               if (tc || !eop_n) begin
                  tc_evt  = 1'b1;
                  state_d = ST_REL;
               end else begin
                  case (act_mode)
                     MD_SINGLE: state_d = ST_REL;
                     MD_BLOCK:  state_d = ST_SVC;
                     MD_DEMAND: if (!eligible[act_q]) state_d = ST_REL;
                     default:   state_d = ST_SVC;
                  endcase
               end
            end
            if (state_d != ST_SVC)
               pri_base_d = act_q + CH_W'(1);
         end
         ST_REL: begin
            if (!hlda)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register writes land first; the TC side effects then override them.
   always_comb begin
      mask_d      = mask_we ? mask_wdata : mask_q;
      req_d       = req_q;
      tc_status_d = status_rd ? '0 : tc_status;
      if (swreq_we)
         req_d[swreq_ch] = swreq_set;
      if (tc_evt) begin
         req_d[act_q]       = 1'b0;
         tc_status_d[act_q] = 1'b1;
         if (!autoinit[act_q])
            mask_d[act_q] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q   <= ST_IDLE;
         act_q     <= '0;
         pri_base  <= '0;
         dreq_q    <= '0;
         mask_q    <= '1;
         req_q     <= '0;
         tc_status <= '0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         pri_base  <= pri_base_d;
         dreq_q    <= dreq ^ {NCH{~dreq_pol}};
         mask_q    <= mask_d;
         req_q     <= req_d;
         tc_status <= tc_status_d;
      end
   end

   assign hrq       = (state_q == ST_REQ) || (state_q == ST_SVC);
   assign svc_valid = (state_q == ST_SVC);
   assign act_ch    = act_q;
   assign dack_int  = svc_valid ? ({{(NCH-1){1'b0}}, 1'b1} << act_q) : '0;
   assign dack      = dack_pol ? dack_int : ~dack_int;

endmodule

// File: tb/tb_dma_service_arbiter.sv
// Bench for dma_service_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural model of the service rules.
module tb_dma_service_arbiter;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] dreq;
   logic       dreq_pol, dack_pol, rot_pri, ctrl_disable;
   logic [7:0] mode;
   logic [3:0] autoinit;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       swreq_we;
   logic [1:0] swreq_ch;
   logic       swreq_set, status_rd, hlda, xfer_done, tc, eop_n;
   logic       hrq, svc_valid;
   logic [3:0] dack, mask_q, req_q, tc_status;
   logic [1:0] act_ch;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   bit         m_hrq, m_svc, m_rel;
   int         m_act, m_base;
   logic [3:0] m_dq, m_rq, m_mask, m_tc;

   dma_service_arbiter #(.NCH(4), .CH_W(2)) dut (
      .CLK(CLK), .RESET(RESET), .dreq(dreq), .dreq_pol(dreq_pol),
      .dack_pol(dack_pol), .rot_pri(rot_pri), .ctrl_disable(ctrl_disable),
      .mode(mode), .autoinit(autoinit), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .swreq_we(swreq_we), .swreq_ch(swreq_ch),
      .swreq_set(swreq_set), .status_rd(status_rd), .hlda(hlda),
      .xfer_done(xfer_done), .tc(tc), .eop_n(eop_n), .hrq(hrq), .dack(dack),
      .act_ch(act_ch), .svc_valid(svc_valid), .mask_q(mask_q), .req_q(req_q),
      .tc_status(tc_status)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_defaults();
      dreq = 4'h0; dreq_pol = 1'b1; dack_pol = 1'b1; rot_pri = 1'b0;
      ctrl_disable = 1'b0; mode = 8'h55; autoinit = 4'h0;
      mask_we = 1'b0; mask_wdata = 4'h0; swreq_we = 1'b0; swreq_ch = 2'd0;
      swreq_set = 1'b0; status_rd = 1'b0; hlda = 1'b0; xfer_done = 1'b0;
      tc = 1'b0; eop_n = 1'b1;
   endtask

   task automatic apply_reset();
      set_defaults();
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
   endtask

   task automatic write_mask(input logic [3:0] v);
      mask_we = 1'b1; mask_wdata = v;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic wait_svc(input string tag);
      for (int i = 0; i < 12 && svc_valid !== 1'b1; i++) tick();
      checks++;
      if (svc_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: svc_valid never asserted (got %b, need 1)", tag, svc_valid);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (hrq !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b need 0", hrq); end
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL reset_svc: got %b need 0", svc_valid); end
      checks++; if (act_ch !== 2'd0) begin errors++; $display("FAIL reset_act: got %0d need 0", act_ch); end
      checks++; if (dack !== 4'h0) begin errors++; $display("FAIL reset_dack_hi: got %b need 0000", dack); end
      checks++; if (mask_q !== 4'hF) begin errors++; $display("FAIL reset_mask: got %h need f", mask_q); end
      checks++; if (req_q !== 4'h0) begin errors++; $display("FAIL reset_req: got %h need 0", req_q); end
      checks++; if (tc_status !== 4'h0) begin errors++; $display("FAIL reset_tc: got %h need 0", tc_status); end
      dack_pol = 1'b0;
      #1;
      checks++; if (dack !== 4'hF) begin errors++; $display("FAIL reset_dack_lo: got %b need 1111", dack); end
      dack_pol = 1'b1;
   endtask

   task automatic test_fixed_single();
      apply_reset();
      write_mask(4'h0);
      dreq = 4'b1010;
      tick();
      checks++; if (hrq !== 1'b0) begin errors++; $display("FAIL fix_hrq_early: got %b need 0", hrq); end
      tick();
      checks++; if (hrq !== 1'b1) begin errors++; $display("FAIL fix_hrq_latency: got %b need 1", hrq); end
      tick(); tick();
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL fix_no_grant_wo_hlda: got %b need 0", svc_valid); end
      hlda = 1'b1;
      tick();
      checks++; if (act_ch !== 2'd1) begin errors++; $display("FAIL fix_act: got %0d need 1", act_ch); end
      checks++; if (dack !== 4'b0010) begin errors++; $display("FAIL fix_dack: got %b need 0010", dack); end
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      checks++; if (svc_valid !== 1'b0 || hrq !== 1'b0) begin errors++; $display("FAIL fix_rel: got svc=%b hrq=%b need 0/0", svc_valid, hrq); end
      checks++; if (dack !== 4'b0000) begin errors++; $display("FAIL fix_rel_dack: got %b need 0000", dack); end
      hlda = 1'b0;
      tick();
      hlda = 1'b1;
      wait_svc("fix_regrant");
      checks++; if (act_ch !== 2'd1) begin errors++; $display("FAIL fix_act2: got %0d need 1", act_ch); end
   endtask

   task automatic test_rotating();
      apply_reset();
      rot_pri = 1'b1;
      write_mask(4'h0);
      dreq = 4'hF;
      hlda = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_svc("rot_grant");
         checks++;
         if (act_ch !== 2'(k % 4)) begin
            errors++; $display("FAIL rot_order[%0d]: got %0d need %0d", k, act_ch, k % 4);
         end
         xfer_done = 1'b1;
         tick();
         xfer_done = 1'b0;
         hlda = 1'b0;
         tick();
         hlda = 1'b1;
      end
   endtask

   task automatic test_block_tc(input bit ai);
      apply_reset();
      mode = 8'h65;
      autoinit = ai ? 4'b0100 : 4'b0000;
      write_mask(4'h0);
      dreq = 4'b0100;
      hlda = 1'b1;
      wait_svc("blk_grant");
      for (int p = 0; p < 3; p++) begin
         xfer_done = 1'b1; tc = (p == 2);
         tick();
         xfer_done = 1'b0; tc = 1'b0;
         if (p < 2) begin
            tick();
            checks++;
            if (svc_valid !== 1'b1 || act_ch !== 2'd2) begin
               errors++; $display("FAIL blk_burst[%0d]: got svc=%b act=%0d need 1/2", p, svc_valid, act_ch);
            end
         end
      end
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL blk_end: got %b need 0", svc_valid); end
      checks++; if (tc_status !== 4'b0100) begin errors++; $display("FAIL blk_tc: got %b need 0100", tc_status); end
      checks++;
      if (mask_q !== (ai ? 4'b0000 : 4'b0100)) begin
         errors++; $display("FAIL blk_mask(ai=%0d): got %b need %b", ai, mask_q, ai ? 4'b0000 : 4'b0100);
      end
      dreq = 4'h0;
   endtask

   task automatic test_demand();
      apply_reset();
      mode = 8'h54;
      write_mask(4'h0);
      dreq = 4'b0001;
      hlda = 1'b1;
      wait_svc("dem_grant");
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      checks++; if (svc_valid !== 1'b1) begin errors++; $display("FAIL dem_stay: got %b need 1", svc_valid); end
      dreq = 4'b0000;
      tick();
      checks++; if (svc_valid !== 1'b1) begin errors++; $display("FAIL dem_wait: got %b need 1", svc_valid); end
      xfer_done = 1'b1;
      tick();
      xfer_done = 1'b0;
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL dem_rel: got %b need 0", svc_valid); end
      checks++; if (tc_status !== 4'b0000) begin errors++; $display("FAIL dem_no_tc: got %b need 0000", tc_status); end

      apply_reset();
      mode = 8'h54;
      write_mask(4'h0);
      dreq = 4'b0001;
      hlda = 1'b1;
      wait_svc("dem_eop_grant");
      xfer_done = 1'b1; eop_n = 1'b0;
      tick();
      xfer_done = 1'b0; eop_n = 1'b1;
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL dem_eop_rel: got %b need 0", svc_valid); end
      checks++; if (tc_status !== 4'b0001) begin errors++; $display("FAIL dem_eop_tc: got %b need 0001", tc_status); end
      checks++; if (mask_q !== 4'b0001) begin errors++; $display("FAIL dem_eop_mask: got %b need 0001", mask_q); end
   endtask

   task automatic test_swreq();
      apply_reset();
      write_mask(4'b0111);
      swreq_we = 1'b1; swreq_ch = 2'd3; swreq_set = 1'b1;
      tick();
      swreq_we = 1'b0;
      checks++; if (req_q !== 4'b1000) begin errors++; $display("FAIL sw_req_set: got %b need 1000", req_q); end
      hlda = 1'b1;
      wait_svc("sw_grant");
      checks++; if (act_ch !== 2'd3 || dack !== 4'b1000) begin errors++; $display("FAIL sw_grant_ch: got act=%0d dack=%b need 3/1000", act_ch, dack); end
      xfer_done = 1'b1; tc = 1'b1; status_rd = 1'b1;
      swreq_we = 1'b1; mask_we = 1'b1; mask_wdata = 4'h0;
      tick();
      xfer_done = 1'b0; tc = 1'b0; status_rd = 1'b0; swreq_we = 1'b0; mask_we = 1'b0;
      checks++; if (req_q !== 4'b0000) begin errors++; $display("FAIL sw_tc_clear: got %b need 0000", req_q); end
      checks++; if (tc_status !== 4'b1000) begin errors++; $display("FAIL sw_tc_vs_rd: got %b need 1000", tc_status); end
      checks++; if (mask_q !== 4'b1000) begin errors++; $display("FAIL sw_mask_merge: got %b need 1000", mask_q); end
      checks++; if (svc_valid !== 1'b0) begin errors++; $display("FAIL sw_rel: got %b need 0", svc_valid); end
   endtask

   task automatic test_reset_mid_svc();
      apply_reset();
      write_mask(4'h0);
      dreq = 4'b0010;
      hlda = 1'b1;
      wait_svc("rst_grant");
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      checks++; if (hrq !== 1'b0 || svc_valid !== 1'b0) begin errors++; $display("FAIL rst_svc_ctl: got hrq=%b svc=%b need 0/0", hrq, svc_valid); end
      checks++; if (dack !== 4'b0000) begin errors++; $display("FAIL rst_svc_dack: got %b need 0000", dack); end
      checks++; if (mask_q !== 4'hF || tc_status !== 4'h0) begin errors++; $display("FAIL rst_svc_regs: got mask=%h tc=%h need f/0", mask_q, tc_status); end
   endtask

   task automatic test_cascade();
      apply_reset();
      mode = 8'h5D;
      write_mask(4'h0);
      dreq = 4'b0010;
      hlda = 1'b1;
      wait_svc("cas_grant");
      checks++; if (act_ch !== 2'd1) begin errors++; $display("FAIL cas_act: got %0d need 1", act_ch); end
      xfer_done = 1'b1; tc = 1'b1;
      tick();
      xfer_done = 1'b0; tc = 1'b0;
      checks++; if (svc_valid !== 1'b1 || tc_status !== 4'h0) begin errors++; $display("FAIL cas_ignore_xfer: got svc=%b tc=%b need 1/0000", svc_valid, tc_status); end
      dreq = 4'b0000;
      tick();
      checks++; if (dack !== 4'b0010) begin errors++; $display("FAIL cas_hold: got %b need 0010", dack); end
      tick();
      checks++; if (dack !== 4'b0000 || svc_valid !== 1'b0) begin errors++; $display("FAIL cas_release: got dack=%b svc=%b need 0000/0", dack, svc_valid); end
   endtask

   // One clock of the service rules, evaluated on the inputs seen at the edge.
   task automatic model_step();
      logic [3:0] elig, mask_n, req_n, tc_n;
      int         win, a, base, md;
      bit         tcev, fin;
      if (!RESET) begin
         m_hrq = 0; m_svc = 0; m_rel = 0; m_act = 0; m_base = 0;
         m_dq = 4'h0; m_rq = 4'h0; m_mask = 4'hF; m_tc = 4'h0;
         return;
      end
      for (int c = 0; c < 4; c++) begin
         if (mode[2*c +: 2] == 2'b11) elig[c] = m_dq[c] & ~m_mask[c];
         else                         elig[c] = (m_dq[c] | m_rq[c]) & ~m_mask[c];
      end
      win = -1;
      base = rot_pri ? m_base : 0;
      for (int i = 0; i < 4; i++)
         if (win < 0 && elig[(base + i) % 4]) win = (base + i) % 4;
      a = m_act;
      md = int'(mode[2*a +: 2]);
      tcev = 0; fin = 0;
      if (m_svc) begin
         if (!hlda) fin = 1;
         else if (md == 3) fin = !m_dq[a];
         else if (xfer_done) begin
            if (tc || !eop_n) begin tcev = 1; fin = 1; end
            else if (md == 1) fin = 1;
            else if (md == 0) fin = !elig[a];
         end
      end
      mask_n = mask_we ? mask_wdata : m_mask;
      req_n = m_rq;
      if (swreq_we) req_n[swreq_ch] = swreq_set;
      tc_n = status_rd ? 4'h0 : m_tc;
      if (tcev) begin
         req_n[a] = 1'b0;
         tc_n[a]  = 1'b1;
         if (!autoinit[a]) mask_n[a] = 1'b1;
      end
      if (m_svc) begin
         if (fin) begin m_svc = 0; m_hrq = 0; m_rel = 1; m_base = (a + 1) % 4; end
      end else if (m_rel) begin
         if (!hlda) m_rel = 0;
      end else if (m_hrq) begin
         if (hlda) begin
            if (win >= 0) begin m_svc = 1; m_act = win; end
            else begin m_hrq = 0; m_rel = 1; end
         end
      end else if (!ctrl_disable && win >= 0) begin
         m_hrq = 1;
      end
      m_mask = mask_n; m_rq = req_n; m_tc = tc_n;
      m_dq = dreq ^ {4{~dreq_pol}};
   endtask

   task automatic test_random();
      logic [3:0] e_dack;
      set_defaults();
      for (int cyc = 0; cyc < 3000 && errors < 20; cyc++) begin
         @(negedge CLK);
         RESET = (cyc == 0 || $urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         if (cyc % 50 == 0) begin
            dreq_pol = 1'($urandom); dack_pol = 1'($urandom); rot_pri = 1'($urandom);
            mode = 8'($urandom); autoinit = 4'($urandom);
         end
         if ($urandom_range(0, 4) == 0) dreq = 4'($urandom);
         ctrl_disable = ($urandom_range(0, 9) == 0);
         mask_we = ($urandom_range(0, 19) == 0);
         mask_wdata = 4'($urandom) & 4'($urandom);
         swreq_we = ($urandom_range(0, 11) == 0);
         swreq_ch = 2'($urandom); swreq_set = 1'($urandom);
         status_rd = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) != 0) hlda = m_hrq;
         else if ($urandom_range(0, 3) == 0) hlda = ~hlda;
         xfer_done = ($urandom_range(0, 99) < 35);
         tc = ($urandom_range(0, 99) < 15);
         eop_n = ($urandom_range(0, 9) != 0);
         @(posedge CLK);
         model_step();
         #1;
         e_dack = m_svc ? 4'(1 << m_act) : 4'h0;
         if (!dack_pol) e_dack = ~e_dack;
         checks++; if (hrq !== m_hrq) begin errors++; $display("FAIL rnd_hrq@%0d: got %b need %b", cyc, hrq, m_hrq); end
         checks++; if (svc_valid !== m_svc) begin errors++; $display("FAIL rnd_svc@%0d: got %b need %b", cyc, svc_valid, m_svc); end
         checks++; if (act_ch !== 2'(m_act)) begin errors++; $display("FAIL rnd_act@%0d: got %0d need %0d", cyc, act_ch, m_act); end
         checks++; if (dack !== e_dack) begin errors++; $display("FAIL rnd_dack@%0d: got %b need %b", cyc, dack, e_dack); end
         checks++; if (mask_q !== m_mask) begin errors++; $display("FAIL rnd_mask@%0d: got %b need %b", cyc, mask_q, m_mask); end
         checks++; if (req_q !== m_rq) begin errors++; $display("FAIL rnd_req@%0d: got %b need %b", cyc, req_q, m_rq); end
         checks++; if (tc_status !== m_tc) begin errors++; $display("FAIL rnd_tc@%0d: got %b need %b", cyc, tc_status, m_tc); end
      end
   endtask

   initial begin
      set_defaults();
      RESET = 1'b0;
      tick();
      test_reset();
      test_fixed_single();
      test_rotating();
      test_block_tc(1'b0);
      test_block_tc(1'b1);
      test_demand();
      test_swreq();
      test_reset_mid_svc();
      test_cascade();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
